// File: rtl/controlador_rega_if.sv
// Bus bundle for the irrigation controller: enable/time-base/sensor inputs and valve/status outputs.
// ciclos exists only when REGA_CONTADOR_EN is defined.
interface controlador_rega_if;
  logic       habilita;
  logic       tick;
  logic       umidade_baixa;
  logic       umidade_critica;
  logic       nivel_baixo;
  logic       aspersao;
  logic       gotejamento;
  logic       enchimento;
  logic       alarme;
  logic [2:0] estado;
`ifdef REGA_CONTADOR_EN
  logic [7:0] ciclos;
`endif

  modport master (
`ifdef REGA_CONTADOR_EN
    input  ciclos,
`endif
    output habilita, tick, umidade_baixa, umidade_critica, nivel_baixo,
    input  aspersao, gotejamento, enchimento, alarme, estado
  );

  modport slave (
`ifdef REGA_CONTADOR_EN
    output ciclos,
`endif
    input  habilita, tick, umidade_baixa, umidade_critica, nivel_baixo,
    output aspersao, gotejamento, enchimento, alarme, estado
  );
endinterface

// File: rtl/controlador_rega.sv
// Irrigation valve controller: Moore FSM with dead-time, minimum on-time and timeout alarm.
// Optional irrigation-cycle counter output ciclos enabled by defining REGA_CONTADOR_EN.
module controlador_rega #(
  parameter int unsigned T_MIN   = 4,
  parameter int unsigned T_PAUSA = 2,
  parameter int unsigned T_MAX   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  controlador_rega_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    PAUSA       = 3'd1,
    ASPERSAO    = 3'd2,
    GOTEJAMENTO = 3'd3,
    ENCHENDO    = 3'd4,
    ALARME      = 3'd5
  } estado_t;

  localparam logic [7:0] CNT_PAUSA = 8'(T_PAUSA);
  localparam logic [7:0] CNT_MIN   = 8'(T_MIN);
  localparam logic [7:0] CNT_MAX   = 8'(T_MAX);

  estado_t    estado_q, estado_d;
  estado_t    alvo_q, alvo_d;
  estado_t    demanda;
  logic [7:0] cnt_q, cnt_d;
  logic       aspersao_q, gotejamento_q, enchimento_q, alarme_q;

  always_comb begin
    if (bus.umidade_critica)    demanda = ASPERSAO;
    else if (bus.umidade_baixa) demanda = GOTEJAMENTO;
    else                        demanda = OCIOSO;
  end

  always_comb begin
    estado_d = estado_q;
    alvo_d   = alvo_q;
    if (!bus.habilita) begin
      estado_d = OCIOSO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (bus.nivel_baixo) begin
            estado_d = ENCHENDO;
          end else if (demanda != OCIOSO) begin
            estado_d = PAUSA;
            alvo_d   = demanda;
          end
        end
        PAUSA: begin
          if (bus.nivel_baixo)         estado_d = ENCHENDO;
          else if (cnt_q == CNT_PAUSA) estado_d = alvo_q;
        end
        ASPERSAO, GOTEJAMENTO: begin
          // Timeout beats low tank, which beats the minimum on-time hold.
          if (cnt_q == CNT_MAX) begin
            estado_d = ALARME;
          end else if (bus.nivel_baixo) begin
            estado_d = ENCHENDO;
          end else if (cnt_q >= CNT_MIN) begin
            if (demanda == OCIOSO) begin
              estado_d = OCIOSO;
            end else if (demanda != estado_q) begin
              estado_d = PAUSA;
              alvo_d   = demanda;
            end
          end
        end
        ENCHENDO: begin
          if (cnt_q == CNT_MAX)      estado_d = ALARME;
          else if (!bus.nivel_baixo) estado_d = OCIOSO;
        end
        ALARME:  estado_d = ALARME;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (estado_d != estado_q)         cnt_d = '0;
    else if (bus.tick && cnt_q != '1) cnt_d = cnt_q + 8'd1;
  end

  // Valve flags are decoded from the next state so they switch on the same edge as estado.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= OCIOSO;
      alvo_q        <= GOTEJAMENTO;
      cnt_q         <= '0;
      aspersao_q    <= 1'b0;
      gotejamento_q <= 1'b0;
      enchimento_q  <= 1'b0;
      alarme_q      <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      alvo_q        <= alvo_d;
      cnt_q         <= cnt_d;
      aspersao_q    <= (estado_d == ASPERSAO);
      gotejamento_q <= (estado_d == GOTEJAMENTO);
      enchimento_q  <= (estado_d == ENCHENDO);
      alarme_q      <= (estado_d == ALARME);
    end
  end

  assign bus.estado      = estado_q;
  assign bus.aspersao    = aspersao_q;
  assign bus.gotejamento = gotejamento_q;
  assign bus.enchimento  = enchimento_q;
  assign bus.alarme      = alarme_q;

`ifdef REGA_CONTADOR_EN
  logic [7:0] ciclos_q, ciclos_d;
  logic       fim_irrigacao;

  assign fim_irrigacao = ((estado_q == ASPERSAO) || (estado_q == GOTEJAMENTO)) &&
                         (estado_d != estado_q) && (estado_d != ALARME);

  always_comb begin
    ciclos_d = ciclos_q;
    if (fim_irrigacao && ciclos_q != '1) ciclos_d = ciclos_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ciclos_q <= '0;
    else          ciclos_q <= ciclos_d;
  end

  assign bus.ciclos = ciclos_q;
`endif

endmodule

// File: tb/tb_controlador_rega.sv
// Self-checking bench for controlador_rega: directed scenarios plus random stimulus vs. a reference model.
module tb_controlador_rega;
  localparam int TP   = 2;
  localparam int TMIN = 4;
  localparam int TM   = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  controlador_rega_if bus ();

  controlador_rega #(.T_MIN(TMIN), .T_PAUSA(TP), .T_MAX(TM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: state codes as plain integers (0..5), tick counter, pending target, cycle count.
  int m_st, m_cnt, m_alvo, m_cic;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    if (obs !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int desired_valve(input logic crit, input logic baixa);
    if (crit)  return 2;
    if (baixa) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_alvo = 3; m_cic = 0;
  endtask

  task automatic model_edge();
    int prev = m_st;
    int nxt  = m_st;
    int want = desired_valve(bus.umidade_critica, bus.umidade_baixa);
    if (!bus.habilita) nxt = 0;
    else if (prev == 0) begin
      if (bus.nivel_baixo) nxt = 4;
      else if (want != 0) begin nxt = 1; m_alvo = want; end
    end else if (prev == 1) begin
      if (bus.nivel_baixo) nxt = 4;
      else if (m_cnt == TP) nxt = m_alvo;
    end else if (prev == 2 || prev == 3) begin
      if (m_cnt == TM) nxt = 5;
      else if (bus.nivel_baixo) nxt = 4;
      else if (m_cnt >= TMIN && want != prev) begin
        if (want == 0) nxt = 0;
        else begin nxt = 1; m_alvo = want; end
      end
    end else if (prev == 4) begin
      if (m_cnt == TM) nxt = 5;
      else if (!bus.nivel_baixo) nxt = 0;
    end
    if (nxt != prev) begin
      if ((prev == 2 || prev == 3) && nxt != 5 && m_cic < 255) m_cic++;
      m_cnt = 0;
    end else if (bus.tick && m_cnt < 255) begin
      m_cnt++;
    end
    m_st = nxt;
  endtask

  task automatic check_all();
    check("estado",      32'(bus.estado),  m_st);
    check("aspersao",    32'(bus.aspersao),    int'(m_st == 2));
    check("gotejamento", 32'(bus.gotejamento), int'(m_st == 3));
    check("enchimento",  32'(bus.enchimento),  int'(m_st == 4));
    check("alarme",      32'(bus.alarme),      int'(m_st == 5));
    check("exclusao", 32'((int'(bus.aspersao) + int'(bus.gotejamento) + int'(bus.enchimento)) <= 1), 1);
`ifdef REGA_CONTADOR_EN
    check("ciclos", 32'(bus.ciclos), m_cic);
`endif
  endtask

  task automatic step(input logic tk);
    bus.tick = tk;
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step(cyc % 4 == 0);
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int k = 0;
    while (bus.estado != 3'(target) && k < budget) begin
      run(1);
      k++;
    end
    check(tag, 32'(bus.estado), target);
  endtask

  initial begin
    bus.habilita = 1'b0; bus.tick = 1'b0; bus.umidade_baixa = 1'b0;
    bus.umidade_critica = 1'b0; bus.nivel_baixo = 1'b0;
    model_reset();
    #12;
    check_all();
    reset_n = 1'b1;
    #1;
    check("pos_reset_estado", 32'(bus.estado), 0);
    bus.habilita = 1'b1;

    // Sprinkling demand, then drop it: valve must stay until minimum on-time.
    bus.umidade_critica = 1'b1;
    wait_state("asp_apos_pausa", 2, 40);
    run(4);
    bus.umidade_critica = 1'b0;
    run(1);
    check("asp_retido", 32'(bus.aspersao), 1);
    wait_state("ocioso_apos_min", 0, 40);

    // Switch sprinkler -> drip via dead time.
    bus.umidade_critica = 1'b1;
    wait_state("asp_2", 2, 40);
    run(20);
    bus.umidade_critica = 1'b0; bus.umidade_baixa = 1'b1;
    run(1);
    check("troca_pausa", 32'(bus.estado), 1);
    wait_state("got_apos_troca", 3, 40);

    // Low tank during drip overrides minimum on-time.
    run(4);
    bus.nivel_baixo = 1'b1;
    run(1);
    check("ench_gotej", 32'(bus.gotejamento), 0);
    check("ench_ench",  32'(bus.enchimento), 1);
    bus.nivel_baixo = 1'b0;
    run(1);
    check("ench_fim", 32'(bus.estado), 0);

    // Hold drip demand until timeout, then clear with habilita.
    wait_state("got_3", 3, 40);
    wait_state("timeout", 5, 120);
    check("alarme_on", 32'(bus.alarme), 1);
    run(3);
    bus.habilita = 1'b0;
    run(1);
    check("alarme_off", 32'(bus.alarme), 0);
    check("alarme_ocioso", 32'(bus.estado), 0);
    bus.habilita = 1'b1; bus.umidade_baixa = 1'b0;

    // Asynchronous reset in the middle of sprinkling.
    bus.umidade_critica = 1'b1;
    wait_state("asp_4", 2, 40);
    run(2);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_asp",    32'(bus.aspersao), 0);
    check("rst_async_estado", 32'(bus.estado), 0);
    check_all();
    #2;
    reset_n = 1'b1;
    bus.umidade_critica = 1'b0;

    // Random stimulus with slowly varying sensors.
    for (int i = 0; i < 4000; i++) begin
      if (bus.habilita) begin
        if ($urandom_range(0, 299) == 0) bus.habilita = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.habilita = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) bus.umidade_critica = ~bus.umidade_critica;
      if ($urandom_range(0, 29) == 0) bus.umidade_baixa   = ~bus.umidade_baixa;
      if ($urandom_range(0, 59) == 0) bus.nivel_baixo     = ~bus.nivel_baixo;
      step($urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/controlador_rega.md
CONTROLADOR_REGA -- requirements
Module: controlador_rega

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter T_MIN, default 4: minimum irrigation on-time, in ticks.
REQ-003 Parameter T_PAUSA, default 2: dead time, in ticks, with all valves closed before any valve opens.
REQ-004 Parameter T_MAX, default 16: timeout, in ticks, for the irrigation and fill states.
REQ-005 clock  input  1  system clock, rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 habilita  input  1  controller enable; low forces OCIOSO.
REQ-008 tick  input  1  one-cycle time-base pulse.
REQ-009 umidade_baixa  input  1  soil moisture is low.
REQ-010 umidade_critica  input  1  soil moisture is critical; has priority over umidade_baixa.
REQ-011 nivel_baixo  input  1  water tank is low.
REQ-012 aspersao  output  1  sprinkler valve.
REQ-013 gotejamento  output  1  drip valve.
REQ-014 enchimento  output  1  tank fill valve.
REQ-015 alarme  output  1  fault indication.
REQ-016 estado  output  3  current state code: OCIOSO=0, PAUSA=1, ASPERSAO=2, GOTEJAMENTO=3, ENCHENDO=4, ALARME=5.

Function
REQ-017 All outputs SHALL be registered Moore decodes of the state register and SHALL change on the same clock edge as the state.
REQ-018 aspersao, gotejamento and enchimento SHALL be mutually exclusive in every cycle; at most one SHALL be 1.
REQ-019 An 8-bit saturating counter cnt SHALL clear on every state change and SHALL increment on each cycle where tick=1 and the state is unchanged.
REQ-020 OCIOSO, priority order: nivel_baixo -> ENCHENDO; else umidade_critica -> PAUSA with alvo=ASPERSAO; else umidade_baixa -> PAUSA with alvo=GOTEJAMENTO; else stay in OCIOSO.
REQ-021 PAUSA: all valves SHALL be closed; when cnt=T_PAUSA the block SHALL go to alvo; if nivel_baixo rises first, it SHALL go to ENCHENDO.
REQ-022 ASPERSAO and GOTEJAMENTO: before cnt reaches T_MIN the block SHALL ignore moisture changes.
REQ-023 ASPERSAO and GOTEJAMENTO: once cnt>=T_MIN, the block SHALL re-evaluate demand per REQ-020; the same demand SHALL mean stay; a different valve SHALL mean PAUSA with the new alvo; no demand SHALL mean OCIOSO.
REQ-024 nivel_baixo=1 in ASPERSAO or GOTEJAMENTO SHALL go to ENCHENDO on the next edge, overriding T_MIN.
REQ-025 cnt=T_MAX in ASPERSAO, GOTEJAMENTO or ENCHENDO SHALL go to ALARME; the timeout SHALL take priority over every other transition from that state.
REQ-026 ENCHENDO: enchimento=1; when nivel_baixo=0 the block SHALL go to OCIOSO.
REQ-027 ALARME: alarme=1 and all valves closed; the state SHALL be held until habilita=0.
REQ-028 habilita=0 SHALL force OCIOSO from any state on the next edge, clearing alarme; this SHALL take the highest priority.
REQ-029 Simultaneous tick and state change: the counter clear SHALL win.

Reset
REQ-030 reset_n=0 SHALL asynchronously set estado=OCIOSO, cnt=0, alvo=GOTEJAMENTO and all outputs to 0, including ciclos when compiled in.
REQ-031 Reset mid-irrigation SHALL close all valves immediately, without waiting for a clock edge.
REQ-032 After reset_n rises, the first transition SHALL occur no earlier than the first clock edge.

Configuration
REQ-033 With REGA_CONTADOR_EN defined, an output ciclos[7:0] SHALL exist and SHALL increment, saturating at 255, on each exit from ASPERSAO or GOTEJAMENTO that is not to ALARME.
REQ-034 Without REGA_CONTADOR_EN, neither the ciclos port nor its logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-035 umidade_critica=1 with tick every 4 cycles -> PAUSA for 2 ticks, then aspersao=1; drop the demand after 1 tick -> aspersao held until cnt=4.
REQ-036 In ASPERSAO at cnt>=4, set umidade_critica=0, umidade_baixa=1 -> aspersao=0, PAUSA for 2 ticks, then gotejamento=1; no cycle has both valves at 1.
REQ-037 Raise nivel_baixo at GOTEJAMENTO cnt=1 -> next edge gotejamento=0, enchimento=1; clear nivel_baixo -> OCIOSO.
REQ-038 Hold umidade_baixa=1 for 16 ticks in GOTEJAMENTO -> alarme=1, estado=5; habilita=0 -> OCIOSO and alarme=0.
REQ-039 Assert reset_n=0 mid-ASPERSAO, between clock edges -> outputs 0 immediately, estado=0.
REQ-040 With REGA_CONTADOR_EN defined, 3 normal cycles -> ciclos=3; 1 timeout -> ciclos unchanged.
